// File: rtl/axi4_stream_pkt_limiter_pkg.sv
// Shared types for the packet-length limiter. Optional statistics are enabled
// with the AXI4_STREAM_PKT_LIMITER_STAT_EN macro.
package axi4_stream_pkt_limiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DISCARD
    } limiterState_e;

    // Width needed for a beat counter that must reach maxWords without wrapping.
    function automatic int cntWidth(input int maxWords);
        return $clog2(maxWords + 1);
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views, shared by the stream library blocks.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [ID_WIDTH-1:0]     tid;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pipe_reg.sv
// Single-entry registered stage: loads when told to, drains on a downstream
// handshake, and supports load and unload in the same cycle.
module axi4_stream_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstN,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_outReady,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_canLoad
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_outReady) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_canLoad = !r_valid || i_outReady;
endmodule

// File: rtl/axi4_stream_pkt_limiter.sv
// Truncates packets longer than MAX_PKT_WORDS (forcing tlast) and swallows the rest.
// Define AXI4_STREAM_PKT_LIMITER_STAT_EN to add packet/truncation counters.
module axi4_stream_pkt_limiter
    import axi4_stream_pkt_limiter_pkg::*;
#(
    parameter int MAX_PKT_WORDS = 64,
    parameter int DATA_WIDTH    = 32,
    parameter int USER_WIDTH    = 1,
    parameter int DEST_WIDTH    = 1,
    parameter int ID_WIDTH      = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    axi4_stream_if.slave        pkt_i,
    axi4_stream_if.master       pkt_o,
    output logic                trunc_o,
    output logic                busy_o
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
    ,
    output logic [31:0]         pkt_cnt_o,
    output logic [31:0]         trunc_cnt_o
`endif
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CNT_W  = cntWidth(MAX_PKT_WORDS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_WORDS);

    // Word layout depends on this instance's widths, so it lives here.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_W-1:0]     tstrb;
        logic [KEEP_W-1:0]     tkeep;
        logic                  tlast;
        logic [USER_WIDTH-1:0] tuser;
        logic [DEST_WIDTH-1:0] tdest;
        logic [ID_WIDTH-1:0]   tid;
    } word_t;

    limiterState_e    r_state;
    logic [CNT_W-1:0] r_wordCnt;
    logic             r_trunc;

    word_t            w_inWord;
    word_t            w_outWord;
    logic             w_outValid;
    logic             w_canLoad;
    logic             w_inAcc;
    logic             w_load;
    logic             w_forceLast;
    logic [CNT_W-1:0] w_cntNext;

    assign pkt_i.tready = !rst_n_i || w_canLoad || (r_state == DISCARD);
    assign w_inAcc      = pkt_i.tvalid && pkt_i.tready;
    assign w_load       = w_inAcc && (r_state != DISCARD);
    assign w_cntNext    = r_wordCnt + CNT_W'(1);

    // The limit is hit either on the very first word (limit of one) or when
    // this beat would be the MAX_PKT_WORDS-th forwarded word.
    assign w_forceLast = w_inAcc && !pkt_i.tlast &&
                         (((r_state == IDLE) && (MAX_PKT_WORDS == 1)) ||
                          ((r_state == PASS) && (w_cntNext == MAX_CNT)));

    always_comb begin
        w_inWord       = '0;
        w_inWord.tdata = pkt_i.tdata;
        w_inWord.tstrb = pkt_i.tstrb;
        w_inWord.tkeep = pkt_i.tkeep;
        w_inWord.tlast = pkt_i.tlast || w_forceLast;
        w_inWord.tuser = pkt_i.tuser;
        w_inWord.tdest = pkt_i.tdest;
        w_inWord.tid   = pkt_i.tid;
    end

    axi4_stream_pipe_reg #(
        .WIDTH ($bits(word_t))
    ) u_outReg (
        .i_clk      (clk_i),
        .i_rstN     (rst_n_i),
        .i_load     (w_load),
        .i_data     (w_inWord),
        .i_outReady (pkt_o.tready),
        .o_valid    (w_outValid),
        .o_data     (w_outWord),
        .o_canLoad  (w_canLoad)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_wordCnt <= '0;
            r_trunc   <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            if (w_inAcc) begin
                case (r_state)
                    IDLE: begin
                        r_wordCnt <= CNT_W'(1);
                        if (pkt_i.tlast) begin
                            r_state <= IDLE;
                        end else if (w_forceLast) begin
                            r_trunc <= 1'b1;
                            r_state <= DISCARD;
                        end else begin
                            r_state <= PASS;
                        end
                    end
                    PASS: begin
                        r_wordCnt <= w_cntNext;
                        if (pkt_i.tlast) begin
                            r_state <= IDLE;
                        end else if (w_forceLast) begin
                            r_trunc <= 1'b1;
                            r_state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (pkt_i.tlast) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign pkt_o.tvalid = w_outValid;
    assign pkt_o.tdata  = w_outWord.tdata;
    assign pkt_o.tstrb  = w_outWord.tstrb;
    assign pkt_o.tkeep  = w_outWord.tkeep;
    assign pkt_o.tlast  = w_outWord.tlast;
    assign pkt_o.tuser  = w_outWord.tuser;
    assign pkt_o.tdest  = w_outWord.tdest;
    assign pkt_o.tid    = w_outWord.tid;

    assign trunc_o = r_trunc;
    assign busy_o  = (r_state != IDLE) || w_outValid;

`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
    logic [31:0] r_pktCnt;
    logic [31:0] r_truncCnt;

    // Both counters saturate instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pktCnt   <= '0;
            r_truncCnt <= '0;
        end else begin
            if (w_outValid && pkt_o.tready && w_outWord.tlast && (r_pktCnt != 32'hFFFF_FFFF)) begin
                r_pktCnt <= r_pktCnt + 32'd1;
            end
            if (r_trunc && (r_truncCnt != 32'hFFFF_FFFF)) begin
                r_truncCnt <= r_truncCnt + 32'd1;
            end
        end
    end

    assign pkt_cnt_o   = r_pktCnt;
    assign trunc_cnt_o = r_truncCnt;
`endif
endmodule

// File: tb/tb_axi4_stream_pkt_limiter.sv
// Scoreboard bench for axi4_stream_pkt_limiter with MAX_PKT_WORDS=4; also
// checks the counters when AXI4_STREAM_PKT_LIMITER_STAT_EN is defined.
module tb_axi4_stream_pkt_limiter;
    localparam int MAXW = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        dest;
        logic        id;
    } beat_t;

    logic clk = 1'b0;
    logic rstN;
    logic trunc;
    logic busy;
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
    logic [31:0] pktCnt;
    logic [31:0] truncCnt;
`endif

    axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) inIf ();
    axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) outIf ();

    axi4_stream_pkt_limiter #(
        .MAX_PKT_WORDS (MAXW),
        .DATA_WIDTH    (32),
        .USER_WIDTH    (1),
        .DEST_WIDTH    (1),
        .ID_WIDTH      (1)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .pkt_i       (inIf),
        .pkt_o       (outIf),
        .trunc_o     (trunc),
        .busy_o      (busy)
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
        ,
        .pkt_cnt_o   (pktCnt),
        .trunc_cnt_o (truncCnt)
`endif
    );

    always #5 clk = ~clk;

    beat_t expQ[$];
    int    checks = 0;
    int    fails = 0;
    int    truncSeen = 0;
    bit    randomReady = 0;
    beat_t curBeat;
    beat_t heldBeat;
    bit    stalled = 0;

    assign curBeat = {outIf.tdata, outIf.tstrb, outIf.tkeep, outIf.tlast,
                      outIf.tuser, outIf.tdest, outIf.tid};

    function automatic beat_t makeBeat(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.strb = ~d[3:0];
        b.keep = d[3:0];
        b.last = l;
        b.user = d[0];
        b.dest = d[1];
        b.id   = d[2];
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    always @(negedge clk) begin
        beat_t exp;
        if (trunc === 1'b1) truncSeen++;
        if (rstN && stalled) begin
            checkOutput("stall_valid", 64'(outIf.tvalid), 64'd1);
            checkOutput("stall_payload", 64'(curBeat), 64'(heldBeat));
        end
        if (outIf.tvalid === 1'b1 && outIf.tready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_beat: got %h expected none", curBeat);
            end else begin
                exp = expQ.pop_front();
                checkOutput("out_beat", 64'(curBeat), 64'(exp));
            end
        end
        stalled  = (outIf.tvalid === 1'b1) && (outIf.tready === 1'b0);
        heldBeat = curBeat;
    end

    // Sink: always ready, or 50% random while randomReady is set.
    initial begin
        outIf.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            outIf.tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic l, output int waits);
        beat_t b;
        bit    acc;
        b = makeBeat(d, l);
        inIf.tvalid = 1'b1;
        inIf.tdata  = b.data;
        inIf.tstrb  = b.strb;
        inIf.tkeep  = b.keep;
        inIf.tlast  = b.last;
        inIf.tuser  = b.user;
        inIf.tdest  = b.dest;
        inIf.tid    = b.id;
        waits = 0;
        forever begin
            @(negedge clk);
            acc = (inIf.tready === 1'b1);
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                checks++;
                fails++;
                $display("[TB] FAIL input_timeout: got no tready expected tready within 200 cycles");
                break;
            end
        end
        inIf.tvalid = 1'b0;
    endtask

    task automatic sendPacket(input int len, input logic [31:0] base);
        int w;
        for (int i = 0; i < len; i++) begin
            if (i < MAXW) expQ.push_back(makeBeat(base + 32'(i), (i == len - 1) || (i == MAXW - 1)));
            applyStimulus(base + 32'(i), i == len - 1, w);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int t0;
        rstN        = 1'b0;
        inIf.tvalid = 1'b0;
        inIf.tdata  = '0;
        inIf.tstrb  = '0;
        inIf.tkeep  = '0;
        inIf.tlast  = 1'b0;
        inIf.tuser  = '0;
        inIf.tdest  = '0;
        inIf.tid    = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tready", 64'(inIf.tready), 64'd1);
        checkOutput("reset_tvalid", 64'(outIf.tvalid), 64'd0);
        checkOutput("reset_trunc", 64'(trunc), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_tdata", 64'(outIf.tdata), 64'd0);
        checkOutput("reset_tlast", 64'(outIf.tlast), 64'd0);
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
        checkOutput("reset_pkt_cnt", 64'(pktCnt), 64'd0);
        checkOutput("reset_trunc_cnt", 64'(truncCnt), 64'd0);
`endif
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 1: 3-beat packet");
        t0 = truncSeen;
        expQ.push_back(makeBeat(32'h31, 1'b0));
        expQ.push_back(makeBeat(32'h32, 1'b0));
        expQ.push_back(makeBeat(32'h33, 1'b1));
        applyStimulus(32'h31, 1'b0, w);
        checkOutput("latency_valid", 64'(outIf.tvalid), 64'd1);
        checkOutput("latency_busy", 64'(busy), 64'd1);
        applyStimulus(32'h32, 1'b0, w);
        applyStimulus(32'h33, 1'b1, w);
        waitDrain(50);
        checkOutput("t1_trunc_count", 64'(truncSeen - t0), 64'd0);
        checkOutput("t1_idle_busy", 64'(busy), 64'd0);

        $display("[TB] test 2: exactly 4-beat packet");
        t0 = truncSeen;
        sendPacket(4, 32'h40);
        waitDrain(50);
        checkOutput("t2_trunc_count", 64'(truncSeen - t0), 64'd0);
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
        checkOutput("t2_pkt_cnt", 64'(pktCnt), 64'd2);
`endif

        $display("[TB] test 3: 7-beat packet truncated");
        t0 = truncSeen;
        expQ.push_back(makeBeat(32'h10, 1'b0));
        expQ.push_back(makeBeat(32'h11, 1'b0));
        expQ.push_back(makeBeat(32'h12, 1'b0));
        expQ.push_back(makeBeat(32'h13, 1'b1));
        for (int i = 0; i < 7; i++) begin
            applyStimulus(32'h10 + 32'(i), i == 6, w);
            if (i >= 4) checkOutput("t3_discard_no_wait", 64'(w), 64'd0);
        end
        sendPacket(2, 32'h20);
        waitDrain(50);
        checkOutput("t3_trunc_count", 64'(truncSeen - t0), 64'd1);
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
        checkOutput("t3_trunc_cnt", 64'(truncCnt), 64'd1);
`endif

        $display("[TB] test 4: 100 packets with random sink stalls");
        t0 = truncSeen;
        randomReady = 1;
        for (int p = 0; p < 100; p++) begin
            sendPacket((p % 8) + 1, 32'h1000 + 32'(p * 16));
        end
        waitDrain(5000);
        randomReady = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t4_trunc_count", 64'(truncSeen - t0), 64'd48);
`ifdef AXI4_STREAM_PKT_LIMITER_STAT_EN
        checkOutput("t4_trunc_cnt", 64'(truncCnt), 64'd49);
`endif

        $display("[TB] test 6: back-to-back 1-beat packets");
        t0 = truncSeen;
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(makeBeat(32'h60 + 32'(i), 1'b1));
            applyStimulus(32'h60 + 32'(i), 1'b1, w);
            checkOutput("t6_no_input_wait", 64'(w), 64'd0);
            checkOutput("t6_out_valid", 64'(outIf.tvalid), 64'd1);
        end
        waitDrain(50);
        checkOutput("t6_trunc_count", 64'(truncSeen - t0), 64'd0);

        $display("[TB] test 5: reset during beat 2");
        t0 = truncSeen;
        expQ.push_back(makeBeat(32'hA0, 1'b0));
        applyStimulus(32'hA0, 1'b0, w);
        inIf.tvalid = 1'b1;
        inIf.tdata  = 32'hA1;
        inIf.tlast  = 1'b0;
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("t5_tready_in_reset", 64'(inIf.tready), 64'd1);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        inIf.tvalid = 1'b0;
        checkOutput("t5_valid_after_reset", 64'(outIf.tvalid), 64'd0);
        checkOutput("t5_busy_after_reset", 64'(busy), 64'd0);
        sendPacket(4, 32'hA2);
        waitDrain(50);
        checkOutput("t5_trunc_count", 64'(truncSeen - t0), 64'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
